// File: rtl/operand_mux_pkg.sv
// -----------------------------------------------------------------------------
// operand_mux_pkg
// Shared types and constants for the operand_mux_n block and its stages.
//   skid_state_t : occupancy of the optional two-entry skid buffer
//   entry_t      : one buffered operand {data, err} at the default 32-bit width
//   ERR_CNT_W    : width of the saturating out-of-range select counter
// -----------------------------------------------------------------------------
package operand_mux_pkg;

    localparam int ERR_CNT_W     = 8;
    localparam int DEFAULT_WIDTH = 32;

    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,   // nothing held
        ONE   = 2'd1,   // output register valid
        TWO   = 2'd2    // output register and skid register both valid
    } skid_state_t;

    typedef struct packed {
        logic [DEFAULT_WIDTH-1:0] data;
        logic                     err;
    } entry_t;

endpackage : operand_mux_pkg

// File: rtl/operand_mux_stage.sv
// -----------------------------------------------------------------------------
// operand_mux_stage
// Single registered entry with a valid/ready handshake on both sides.
// The entry loads whenever the stage is empty or its content is leaving in the
// same cycle, so a full stage streams one entry per cycle without bubbles.
//
// Parameters
//   stage_entry_t : packed entry type carried by the stage
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset; empties the stage and clears the entry
//   in_valid   in   upstream presents in_entry
//   in_ready   out  stage can take in_entry this cycle (combinational)
//   in_entry   in   entry to store
//   out_valid  out  out_entry holds a stored entry
//   out_ready  in   downstream takes out_entry this cycle
//   out_entry  out  stored entry; bit-stable while out_valid && !out_ready
// -----------------------------------------------------------------------------
module operand_mux_stage #(
    parameter type stage_entry_t = operand_mux_pkg::entry_t
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  stage_entry_t in_entry,
    output logic         out_valid,
    input  logic         out_ready,
    output stage_entry_t out_entry
);

    logic         valid_q;
    stage_entry_t entry_q;

    assign in_ready  = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_entry = entry_q;

    // NOTE: the data register is reset as well as the flag, because the block
    // must present all-zero output data while in reset, not stale operands.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            entry_q <= '0;
        end else if (in_valid && in_ready) begin
            valid_q <= 1'b1;
            entry_q <= in_entry;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

endmodule : operand_mux_stage

// File: rtl/operand_mux_n.sv
// -----------------------------------------------------------------------------
// operand_mux_n
// Registered N-way operand selector with valid/ready flow control and a
// saturating count of out-of-range selects. An accepted offer appears on the
// output one cycle later; an out-of-range select yields all-zero data flagged
// by out_sel_err.
//
// Build option (macro OPERAND_MUX_SKID_EN)
//   undefined : single output register, in_ready = !out_valid || out_ready
//   defined   : two-entry skid buffer, in_ready driven from a flop so there is
//               no combinational path from out_ready to in_ready
//
// Parameters
//   WIDTH   operand width in bits
//   NUM_IN  number of operand sources (>= 2)
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-high reset
//   in_valid     in   upstream offers sel/data_in
//   in_ready     out  offer accepted this cycle when in_valid is also high
//   sel          in   source index (SEL_W bits)
//   data_in      in   NUM_IN packed candidate operands, data_in[i] = source i
//   out_valid    out  out_data holds a selected operand
//   out_ready    in   downstream consumes out_data
//   out_data     out  registered selected operand
//   out_sel_err  out  out_data came from a select >= NUM_IN
//   err_cnt      out  saturating count of accepted out-of-range selects
// -----------------------------------------------------------------------------
module operand_mux_n
    import operand_mux_pkg::*;
#(
    parameter  int WIDTH  = 32,
    parameter  int NUM_IN = 4,
    localparam int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [SEL_W-1:0]             sel,
    input  logic [NUM_IN-1:0][WIDTH-1:0] data_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic                         out_sel_err,
    output logic [ERR_CNT_W-1:0]         err_cnt
);

    // Same layout as operand_mux_pkg::entry_t, sized to this instance.
    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             err;
    } mux_entry_t;

    logic                 accept;
    logic                 sel_oob;
    mux_entry_t           new_entry;
    mux_entry_t           out_entry;
    logic [ERR_CNT_W-1:0] err_cnt_q;

    assign accept  = in_valid && in_ready;
    assign sel_oob = (int'(sel) >= NUM_IN);

    // NOTE: every always_comb output gets a default first so no path can leave
    // it unassigned and infer a latch.
    always_comb begin
        new_entry = '0;
        if (sel_oob) begin
            new_entry.err = 1'b1;
        end else begin
            new_entry.data = data_in[sel];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_cnt_q <= '0;
        end else if (accept && sel_oob && (err_cnt_q != ERR_CNT_MAX)) begin
            err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
        end
    end

    assign err_cnt     = err_cnt_q;
    assign out_data    = out_entry.data;
    assign out_sel_err = out_entry.err;

`ifdef OPERAND_MUX_SKID_EN

    skid_state_t state_q, state_d;
    logic        in_ready_q;
    logic        consume;
    logic        out_stage_in_valid;
    logic        out_stage_in_ready;
    mux_entry_t  out_stage_in_entry;
    logic        skid_in_valid;
    logic        skid_in_ready;
    logic        skid_valid;
    mux_entry_t  skid_entry;

    // Gating with reset keeps in_ready low during reset while the flop itself
    // resets high, so the first cycle after release can already accept.
    assign in_ready = in_ready_q && !reset;
    assign consume  = out_valid && out_ready;

    // A held skid entry always has priority into the output register so that
    // entries leave in acceptance order.
    assign out_stage_in_valid = skid_valid || accept;
    assign out_stage_in_entry = skid_valid ? skid_entry : new_entry;

    // Park an accepted entry only when the output register cannot take it.
    assign skid_in_valid = accept && !out_stage_in_ready && skid_in_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: if (accept) state_d = ONE;
            ONE: begin
                if (accept && !consume)      state_d = TWO;
                else if (consume && !accept) state_d = EMPTY;
            end
            TWO:   if (consume) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != TWO);
        end
    end

    operand_mux_stage #(
        .stage_entry_t (mux_entry_t)
    ) u_skid_stage (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (skid_in_valid),
        .in_ready  (skid_in_ready),
        .in_entry  (new_entry),
        .out_valid (skid_valid),
        .out_ready (out_stage_in_ready),
        .out_entry (skid_entry)
    );

    operand_mux_stage #(
        .stage_entry_t (mux_entry_t)
    ) u_out_stage (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (out_stage_in_valid),
        .in_ready  (out_stage_in_ready),
        .in_entry  (out_stage_in_entry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_entry (out_entry)
    );

`else

    logic out_stage_in_ready;

    assign in_ready = out_stage_in_ready && !reset;

    operand_mux_stage #(
        .stage_entry_t (mux_entry_t)
    ) u_out_stage (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (out_stage_in_ready),
        .in_entry  (new_entry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_entry (out_entry)
    );

`endif

endmodule : operand_mux_n

// File: tb/tb_operand_mux_n.sv
// -----------------------------------------------------------------------------
// tb_operand_mux_n
// Directed bench for operand_mux_n. Instance u_dut4 (NUM_IN=4) covers select,
// streaming, stall and reset; instance u_dut3 (NUM_IN=3) covers out-of-range
// selects and counter saturation. Inputs change and outputs are sampled on the
// falling edge. Expectations that differ between builds follow
// OPERAND_MUX_SKID_EN.
// -----------------------------------------------------------------------------
module tb_operand_mux_n;

    localparam int W = 32;

`ifdef OPERAND_MUX_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    logic                a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_sel_err;
    logic [1:0]          a_sel;
    logic [3:0][W-1:0]   a_data_in;
    logic [W-1:0]        a_out_data;
    logic [7:0]          a_err_cnt;

    logic                b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_sel_err;
    logic [1:0]          b_sel;
    logic [2:0][W-1:0]   b_data_in;
    logic [W-1:0]        b_out_data;
    logic [7:0]          b_err_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    operand_mux_n #(.WIDTH(W), .NUM_IN(4)) u_dut4 (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (a_in_valid),
        .in_ready    (a_in_ready),
        .sel         (a_sel),
        .data_in     (a_data_in),
        .out_valid   (a_out_valid),
        .out_ready   (a_out_ready),
        .out_data    (a_out_data),
        .out_sel_err (a_out_sel_err),
        .err_cnt     (a_err_cnt)
    );

    operand_mux_n #(.WIDTH(W), .NUM_IN(3)) u_dut3 (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (b_in_valid),
        .in_ready    (b_in_ready),
        .sel         (b_sel),
        .data_in     (b_data_in),
        .out_valid   (b_out_valid),
        .out_ready   (b_out_ready),
        .out_data    (b_out_data),
        .out_sel_err (b_out_sel_err),
        .err_cnt     (b_err_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    initial begin
        logic took;

        reset       = 1'b1;
        a_in_valid  = 1'b0;
        a_sel       = '0;
        a_data_in   = '0;
        a_out_ready = 1'b1;
        b_in_valid  = 1'b0;
        b_sel       = '0;
        b_data_in   = '0;
        b_out_ready = 1'b1;

        // Reset state
        #2;
        check("rst_out_valid",   32'(a_out_valid),   32'd0);
        check("rst_out_data",    32'(a_out_data),    32'd0);
        check("rst_out_sel_err", 32'(a_out_sel_err), 32'd0);
        check("rst_err_cnt",     32'(a_err_cnt),     32'd0);
        check("rst_in_ready",    32'(a_in_ready),    32'd0);
        check("rst_b_in_ready",  32'(b_in_ready),    32'd0);

        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rel_in_ready",   32'(a_in_ready), 32'd1);
        check("rel_b_in_ready", 32'(b_in_ready), 32'd1);

        // Basic select, accepted at the first edge after reset release
        a_sel      = 2'd2;
        a_data_in  = {32'h3333_3333, 32'hDEAD_BEEF, 32'h1111_1111, 32'h0000_0000};
        a_in_valid = 1'b1;
        @(negedge clk);
        check("sel2_valid", 32'(a_out_valid),   32'd1);
        check("sel2_data",  32'(a_out_data),    32'hDEAD_BEEF);
        check("sel2_err",   32'(a_out_sel_err), 32'd0);
        a_in_valid = 1'b0;
        @(negedge clk);
        check("sel2_drain", 32'(a_out_valid), 32'd0);

        // Back-to-back stream, sel cycling 0..3
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 4; j++) a_data_in[j] = 32'h100 * (i + 1) + j;
            a_sel      = 2'(i % 4);
            a_in_valid = 1'b1;
            check("strm_in_ready", 32'(a_in_ready), 32'd1);
            @(negedge clk);
            check("strm_valid", 32'(a_out_valid), 32'd1);
            check("strm_data",  32'(a_out_data),  32'(32'h100 * (i + 1) + (i % 4)));
        end
        a_in_valid = 1'b0;
        @(negedge clk);
        check("strm_drain", 32'(a_out_valid), 32'd0);

        // Stall: 0x11 held, 0x22 offered
        a_out_ready  = 1'b0;
        a_sel        = 2'd0;
        a_data_in    = '0;
        a_data_in[0] = 32'h11;
        a_in_valid   = 1'b1;
        @(negedge clk);
        check("stall_first", 32'(a_out_data), 32'h11);
        a_sel        = 2'd1;
        a_data_in[1] = 32'h22;
        for (int k = 0; k < 5; k++) begin
            check("stall_in_ready", 32'(a_in_ready),  32'(SKID && (k == 0)));
            check("stall_valid",    32'(a_out_valid), 32'd1);
            check("stall_data",     32'(a_out_data),  32'h11);
            took = a_in_valid && a_in_ready;
            @(negedge clk);
            if (took) a_in_valid = 1'b0;
        end
        a_out_ready = 1'b1;
        check("rel_valid_11", 32'(a_out_valid), 32'd1);
        check("rel_data_11",  32'(a_out_data),  32'h11);
        @(negedge clk);
        a_in_valid = 1'b0;
        check("rel_valid_22", 32'(a_out_valid), 32'd1);
        check("rel_data_22",  32'(a_out_data),  32'h22);
        @(negedge clk);
        check("rel_drain", 32'(a_out_valid), 32'd0);

        // Out-of-range selects on NUM_IN=3 and counter saturation
        b_data_in  = {32'hC2, 32'hB1, 32'hA0};
        b_sel      = 2'd3;
        b_in_valid = 1'b1;
        @(negedge clk);
        check("oob_valid", 32'(b_out_valid),   32'd1);
        check("oob_data",  32'(b_out_data),    32'd0);
        check("oob_err",   32'(b_out_sel_err), 32'd1);
        check("oob_cnt1",  32'(b_err_cnt),     32'd1);
        b_sel = 2'd1;
        @(negedge clk);
        check("inr_data", 32'(b_out_data),    32'hB1);
        check("inr_err",  32'(b_out_sel_err), 32'd0);
        check("inr_cnt",  32'(b_err_cnt),     32'd1);
        b_sel = 2'd3;
        repeat (253) @(negedge clk);
        check("cnt_254", 32'(b_err_cnt), 32'd254);
        @(negedge clk);
        check("cnt_255", 32'(b_err_cnt), 32'd255);
        repeat (45) @(negedge clk);
        check("cnt_sat",     32'(b_err_cnt),     32'd255);
        check("sat_err",     32'(b_out_sel_err), 32'd1);
        check("a_cnt_clean", 32'(a_err_cnt),     32'd0);
        b_in_valid = 1'b0;

        // Reset in the middle of a stall
        a_out_ready  = 1'b0;
        a_sel        = 2'd0;
        a_data_in    = '0;
        a_data_in[0] = 32'hAA;
        a_in_valid   = 1'b1;
        @(negedge clk);
        check("mid_aa", 32'(a_out_data), 32'hAA);
        a_sel        = 2'd1;
        a_data_in[1] = 32'hBB;
        @(negedge clk);
        a_in_valid = 1'b0;
        check("mid_hold", 32'(a_out_data), 32'hAA);
        #2 reset = 1'b1;
        #1;
        check("mrst_valid",    32'(a_out_valid),   32'd0);
        check("mrst_data",     32'(a_out_data),    32'd0);
        check("mrst_err",      32'(a_out_sel_err), 32'd0);
        check("mrst_in_ready", 32'(a_in_ready),    32'd0);
        check("mrst_b_cnt",    32'(b_err_cnt),     32'd0);
        check("mrst_b_valid",  32'(b_out_valid),   32'd0);
        @(negedge clk);
        reset       = 1'b0;
        a_out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("post_valid", 32'(a_out_valid), 32'd0);
            check("post_data",  32'(a_out_data),  32'd0);
        end
        check("post_in_ready", 32'(a_in_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_operand_mux_n
